// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command sequencer: VRAM streaming writes and control-register writes
// Ports:
//   Clk, Reset          system clock, async active-high reset
//   CSel, RecvByte      raw chip select (active-low) and byte-done level from the SPI receiver
//   DataIn              received byte, stable while RecvByte is being resynchronised
//   MemAddr/MemData     VRAM write address/data (FIFO head)
//   MemWe, MemReady     VRAM write valid/ready handshake
//   RegAddr/RegData     control register address/data
//   RegWe               one-cycle control register write strobe
//   Overflow            sticky VRAM byte-dropped flag, cleared on frame start
//   Busy                frame in progress or FIFO not yet drained
module spi_cmd_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CSel,
  input  logic                  RecvByte,
  input  logic [7:0]            DataIn,
  output logic [ADDR_W-1:0]     MemAddr,
  output logic [7:0]            MemData,
  output logic                  MemWe,
  input  logic                  MemReady,
  output logic [REG_ADDR_W-1:0] RegAddr,
  output logic [7:0]            RegData,
  output logic                  RegWe,
  output logic                  Overflow,
  output logic                  Busy
);

  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_ADDR_BYTE = 4'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_RADDR, S_RDATA, S_DISCARD
  } state_t;

  state_t state_q, state_d;

  // Two synchroniser flops plus one history flop for edge detection.
  logic [2:0] csel_q;
  logic [2:0] recv_q;

  logic byte_stb, frame_start, frame_end, byte_ok;
  logic addr_shift, data_byte, reg_addr_ld, reg_wr;

  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W+7:0]     addr_cat;
  logic [3:0]            cnt_q;
  logic [REG_ADDR_W-1:0] reg_addr_q;
  logic [7:0]            reg_data_q;
  logic                  reg_we_q;
  logic                  ovf_q;

  logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full, push, pop, drop;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      csel_q <= 3'b111;
      recv_q <= 3'b000;
    end else begin
      csel_q <= {csel_q[1:0], CSel};
      recv_q <= {recv_q[1:0], RecvByte};
    end
  end

  assign byte_stb    = recv_q[1] & ~recv_q[2];
  assign frame_start = ~csel_q[1] & csel_q[2];
  assign frame_end   = csel_q[1] & ~csel_q[2];
  // A byte coinciding with a chip-select edge belongs to no frame.
  assign byte_ok     = byte_stb & ~frame_start & ~frame_end;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      state_d = S_IDLE;
    end else if (frame_start) begin
      state_d = S_CMD;
    end else if (byte_ok) begin
      case (state_q)
        S_CMD: begin
          if (DataIn == 8'h01)      state_d = S_ADDR;
          else if (DataIn == 8'h02) state_d = S_RADDR;
          else                      state_d = S_DISCARD;
        end
        S_ADDR:  if (cnt_q == LAST_ADDR_BYTE) state_d = S_DATA;
        S_RADDR: state_d = S_RDATA;
        S_RDATA: state_d = S_DISCARD;
        default: state_d = state_q;
      endcase
    end
  end

  // Output/action decode
  always_comb begin
    addr_shift  = 1'b0;
    data_byte   = 1'b0;
    reg_addr_ld = 1'b0;
    reg_wr      = 1'b0;
    case (state_q)
      S_ADDR:  addr_shift  = byte_ok;
      S_DATA:  data_byte   = byte_ok;
      S_RADDR: reg_addr_ld = byte_ok;
      S_RDATA: reg_wr      = byte_ok;
      default: ;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop  = ~fifo_empty & MemReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = data_byte & (~fifo_full | pop);
  assign drop = data_byte & fifo_full & ~pop;

  // Low ADDR_W bits of the shifted concatenation hold the MSB-first address.
  assign addr_cat = {addr_q, DataIn};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_we_q   <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      reg_we_q <= reg_wr;
      if (state_q == S_CMD)  cnt_q <= '0;
      else if (addr_shift)   cnt_q <= cnt_q + 4'd1;
      if (addr_shift)        addr_q <= addr_cat[ADDR_W-1:0];
      else if (data_byte)    addr_q <= addr_q + ADDR_W'(1);
      if (reg_addr_ld)       reg_addr_q <= DataIn[REG_ADDR_W-1:0];
      if (reg_wr)            reg_data_q <= DataIn;
      if (frame_start)       ovf_q <= 1'b0;
      else if (drop)         ovf_q <= 1'b1;
      if (push)              wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)               rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {addr_q, DataIn};
  end

  assign MemWe              = ~fifo_empty;
  assign {MemAddr, MemData} = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign RegAddr            = reg_addr_q;
  assign RegData            = reg_data_q;
  assign RegWe              = reg_we_q;
  assign Overflow           = ovf_q;
  assign Busy               = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        CSel = 1'b1;
  logic        RecvByte = 1'b0;
  logic [7:0]  DataIn = 8'h00;
  logic        MemReady = 1'b1;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        MemWe;
  logic [3:0]  RegAddr;
  logic [7:0]  RegData;
  logic        RegWe;
  logic        Overflow;
  logic        Busy;

  spi_cmd_ctrl dut (
    .Clk(Clk), .Reset(Reset), .CSel(CSel), .RecvByte(RecvByte), .DataIn(DataIn),
    .MemAddr(MemAddr), .MemData(MemData), .MemWe(MemWe), .MemReady(MemReady),
    .RegAddr(RegAddr), .RegData(RegData), .RegWe(RegWe),
    .Overflow(Overflow), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  logic [23:0] obs_mem[$];
  logic [11:0] obs_reg[$];
  logic [23:0] exp_mem[$];
  logic [11:0] exp_reg[$];
  int mi = 0;
  int ri = 0;

  // MemReady: 0 = held low, 1 = held high, 2 = random with a low run never above 4 cycles
  int mr_mode = 1;
  int low_run = 0;
  always @(posedge Clk) begin
    #2;
    if (mr_mode == 0) MemReady = 1'b0;
    else if (mr_mode == 1) MemReady = 1'b1;
    else begin
      if (low_run >= 4) MemReady = 1'b1;
      else MemReady = ($urandom_range(0, 3) != 0);
      low_run = MemReady ? 0 : low_run + 1;
    end
  end

  int regwe_bad = 0;
  int regwe_seen = 0;
  logic regwe_prev = 1'b0;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (MemWe && MemReady) obs_mem.push_back({MemAddr, MemData});
      if (RegWe) begin
        obs_reg.push_back({RegAddr, RegData});
        regwe_seen++;
        if (regwe_prev) regwe_bad++;
      end
    end
    regwe_prev = RegWe;
  end

  typedef struct packed {
    logic [47:0] bytes;
    logic [2:0]  len;
    logic [1:0]  nmem;
    logic [71:0] mem;
    logic        nreg;
    logic [11:0] regw;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1 DataIn = b;
    repeat (2) @(posedge Clk);
    #1 RecvByte = 1'b1;
    repeat (5) @(posedge Clk);
    #1 RecvByte = 1'b0;
    repeat (5) @(posedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    @(posedge Clk); #1 CSel = 1'b0;
    repeat (5) @(posedge Clk);
    foreach (f[i]) send_byte(f[i]);
    repeat (4) @(posedge Clk);
    #1 CSel = 1'b1;
    repeat (5) @(posedge Clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while (Busy && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("drain_within_bound", (n < 400), 1);
  endtask

  task automatic compare_frame(input string tag);
    int no, nr;
    no = obs_mem.size() - mi;
    nr = obs_reg.size() - ri;
    check({tag, "_mem_count"}, no, exp_mem.size());
    for (int i = 0; i < exp_mem.size() && i < no; i++)
      check({tag, "_mem_write"}, obs_mem[mi + i], exp_mem[i]);
    check({tag, "_reg_count"}, nr, exp_reg.size());
    for (int i = 0; i < exp_reg.size() && i < nr; i++)
      check({tag, "_reg_write"}, obs_reg[ri + i], exp_reg[i]);
    mi += no;
    ri += nr;
    exp_mem.delete();
    exp_reg.delete();
  endtask

  // Frame-level reference: what a complete frame should produce once drained.
  task automatic model_frame(input logic [7:0] f[$]);
    logic [15:0] a;
    logic [7:0]  ra;
    if (f.size() >= 3 && f[0] == 8'h01) begin
      a = {f[1], f[2]};
      for (int i = 3; i < f.size(); i++) begin
        exp_mem.push_back({a, f[i]});
        a = a + 16'd1;
      end
    end else if (f.size() >= 3 && f[0] == 8'h02) begin
      ra = f[1];
      exp_reg.push_back({ra[3:0], f[2]});
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]  f[$];
    logic [47:0] tb;
    logic [71:0] tm;
    int          kind, n;

    vecs[0] = '{48'h011234AABBCC, 3'd6, 2'd3, 72'h1234AA_1235BB_1236CC, 1'b0, 12'h000};
    vecs[1] = '{48'h01FFFE112233, 3'd6, 2'd3, 72'hFFFE11_FFFF22_000033, 1'b0, 12'h000};
    vecs[2] = '{48'h02F57E000000, 3'd3, 2'd0, 72'h0,                    1'b1, 12'h57E};
    vecs[3] = '{48'h011200000000, 3'd2, 2'd0, 72'h0,                    1'b0, 12'h000};
    vecs[4] = '{48'h020300000000, 3'd2, 2'd0, 72'h0,                    1'b0, 12'h000};
    vecs[5] = '{48'h7F0102000000, 3'd3, 2'd0, 72'h0,                    1'b0, 12'h000};

    repeat (3) @(negedge Clk);
    check("rst_memwe", MemWe, 0);
    check("rst_regwe", RegWe, 0);
    check("rst_overflow", Overflow, 0);
    check("rst_busy", Busy, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_regaddr_data", {RegAddr, RegData}, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("post_rst_busy", Busy, 0);

    for (int v = 0; v < 6; v++) begin
      f.delete();
      tb = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].len); i++) f.push_back(tb[47 - 8*i -: 8]);
      send_frame(f);
      wait_idle();
      tm = vecs[v].mem;
      for (int i = 0; i < int'(vecs[v].nmem); i++) exp_mem.push_back(tm[71 - 24*i -: 24]);
      if (vecs[v].nreg) exp_reg.push_back(vecs[v].regw);
      compare_frame("vec");
      check("vec_overflow", Overflow, 0);
      check("vec_idle", Busy, 0);
    end

    // FIFO fills with MemReady held low; extra bytes are dropped.
    mr_mode = 0;
    f = '{8'h01, 8'h00, 8'h10, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    send_frame(f);
    @(negedge Clk);
    check("ovf_set", Overflow, 1);
    check("ovf_memwe_held", MemWe, 1);
    check("ovf_busy", Busy, 1);
    compare_frame("ovf_stalled");
    mr_mode = 1;
    exp_mem = '{24'h0010D0, 24'h0011D1, 24'h0012D2, 24'h0013D3};
    wait_idle();
    compare_frame("ovf_drain");
    check("ovf_sticky", Overflow, 1);
    @(posedge Clk); #1 CSel = 1'b0;
    repeat (5) @(negedge Clk);
    check("ovf_clear_on_start", Overflow, 0);
    #1 CSel = 1'b1;
    wait_idle();

    // Randomised frames against the frame-level model.
    mr_mode = 2;
    for (int k = 0; k < 25; k++) begin
      f.delete();
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        f.push_back(8'h01);
        f.push_back((kind == 0) ? 8'hFF : 8'($urandom));
        f.push_back(8'($urandom));
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end else if (kind < 8) begin
        f.push_back(8'h02);
        f.push_back(8'($urandom));
        f.push_back(8'($urandom));
        if (kind == 7) f.push_back(8'($urandom));
      end else if (kind == 8) begin
        f.push_back(8'($urandom_range(3, 255)));
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end else begin
        f.push_back(8'($urandom_range(1, 2)));
        if ($urandom_range(0, 1) == 1) f.push_back(8'($urandom));
      end
      model_frame(f);
      send_frame(f);
      wait_idle();
      compare_frame("rand");
      check("rand_overflow", Overflow, 0);
    end
    mr_mode = 1;

    check("regwe_one_cycle", regwe_bad, 0);

    // Reset in the middle of a data phase with two bytes queued.
    mr_mode = 0;
    @(posedge Clk); #1 CSel = 1'b0;
    repeat (5) @(posedge Clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'hA1);
    send_byte(8'hA2);
    @(negedge Clk);
    check("midrst_queued", MemWe, 1);
    check("midrst_busy_before", Busy, 1);
    Reset = 1'b1;
    #1;
    check("midrst_memwe", MemWe, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_regwe", RegWe, 0);
    CSel = 1'b1;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b0;
    mr_mode = 1;
    repeat (20) @(negedge Clk);
    check("midrst_idle", Busy, 0);
    compare_frame("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
